// File: rtl/edge_det_pkg.sv
// Shared definitions for the multi-channel edge detector: edge-mode encodings
// and the direction/mode match helper.
package edge_det_pkg;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_e;

    function automatic logic edge_match(input logic [1:0] mode, input logic rising);
        if (mode == EDGE_BOTH)
            return 1'b1;
        return rising ? (mode == EDGE_RISE) : (mode == EDGE_FALL);
    endfunction

endpackage

// File: rtl/edge_det_ch.sv
// One input channel: synchroniser, debounce filter, edge qualification,
// sticky event flag and saturating event counter.
module edge_det_ch
    import edge_det_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 3,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_i,
    input  logic [1:0]       mode_i,
    input  logic             en_i,
    input  logic             clr_i,
    output logic             level_o,
    output logic             pulse_o,
    output logic             sticky_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int               DB_W    = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_lvl;
    logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
    logic                   level_q, level_d;
    logic                   pulse_q, pulse_d;
    logic                   sticky_q, sticky_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   toggle;
    logic                   qual;

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    always_comb begin
        db_cnt_d = '0;
        level_d  = level_q;
        toggle   = 1'b0;
        // The counter only holds mismatch cycles; the final one flips the level.
        if (sync_lvl != level_q) begin
            if (db_cnt_q == DB_LAST) begin
                toggle  = 1'b1;
                level_d = ~level_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end

        qual    = en_i & toggle & edge_match(mode_i, ~level_q);
        pulse_d = qual;

        sticky_d = sticky_q;
        count_d  = count_q;
        // A qualified event beats a coincident clear so no event is lost.
        if (qual) begin
            sticky_d = 1'b1;
            if (clr_i)
                count_d = CNT_ONE;
            else if (count_q != CNT_MAX)
                count_d = count_q + 1'b1;
        end else if (clr_i) begin
            sticky_d = 1'b0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '0;
            db_cnt_q <= '0;
            level_q  <= 1'b0;
            pulse_q  <= 1'b0;
            sticky_q <= 1'b0;
            count_q  <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], sig_i};
            db_cnt_q <= db_cnt_d;
            level_q  <= level_d;
            pulse_q  <= pulse_d;
            sticky_q <= sticky_d;
            count_q  <= count_d;
        end
    end

    assign level_o  = level_q;
    assign pulse_o  = pulse_q;
    assign sticky_o = sticky_q;
    assign count_o  = count_q;

endmodule

// File: rtl/edge_det_multi.sv
// Multi-channel debounced edge detector: replicates edge_det_ch per channel
// and ORs the masked sticky flags into a single interrupt.
module edge_det_multi
    import edge_det_pkg::*;
#(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 3,
    parameter int CNT_W       = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CH-1:0]       sig_in,
    input  logic [2*CH-1:0]     mode,
    input  logic                en,
    input  logic [CH-1:0]       clr,
    input  logic [CH-1:0]       irq_mask,
    output logic [CH-1:0]       level_out,
    output logic [CH-1:0]       pulse_out,
    output logic [CH-1:0]       sticky,
    output logic [CH*CNT_W-1:0] count,
    output logic                irq
);

    for (genvar i = 0; i < CH; i++) begin : g_ch
        edge_det_ch #(
            .SYNC_STAGES(SYNC_STAGES),
            .DEBOUNCE   (DEBOUNCE),
            .CNT_W      (CNT_W)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .sig_i   (sig_in[i]),
            .mode_i  (mode[2*i+1:2*i]),
            .en_i    (en),
            .clr_i   (clr[i]),
            .level_o (level_out[i]),
            .pulse_o (pulse_out[i]),
            .sticky_o(sticky[i]),
            .count_o (count[CNT_W*i +: CNT_W])
        );
    end

    assign irq = |(sticky & irq_mask);

endmodule

// File: doc/edge_det_multi.md
Name: edge_det_multi

Overview:
Parametrised multi-channel edge detector; successor to the single-bit XOR edge detector.
Per channel: input synchroniser, debounce filter, per-channel edge-mode select, one-cycle edge pulse, sticky event flag with clear, saturating event counter.
A masked interrupt is aggregated across all channels.
Sits between raw asynchronous inputs (buttons, external strobes) and control logic or a status register bank.

Parameters:
CH, 4, number of independent input channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
DEBOUNCE, 3, consecutive cycles a changed synced level must hold before it is accepted (>=1)
CNT_W, 4, width of each per-channel saturating event counter (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
sig_in  in  CH  raw asynchronous inputs
mode  in  2*CH  per-channel edge select, channel i at [2i+1:2i]: 00 none, 01 rise, 10 fall, 11 both
en  in  1  global detect enable
clr  in  CH  per-channel clear of sticky flag and counter (one-cycle pulse)
irq_mask  in  CH  per-channel interrupt enable
level_out  out  CH  debounced level
pulse_out  out  CH  one-cycle qualified edge pulse
sticky  out  CH  latched event flag
count  out  CH*CNT_W  event counters, channel i at [CNT_W*(i+1)-1:CNT_W*i]
irq  out  1  OR of (sticky & irq_mask)

Behaviour:
- Reset (rst=1 at a clk edge): sync chain, level_out, debounce counters, pulse_out, sticky, count all go to 0; irq=0. Applies mid-operation; a pending debounce is discarded.
- Synchroniser: sig_in passes through SYNC_STAGES flops; sync output reflects sig_in after SYNC_STAGES edges.
- Debounce:
  - Per-channel counter increments each cycle while sync != level_out.
  - Counter resets to 0 on any cycle where sync == level_out.
  - level_out toggles at the edge where the count of mismatching cycles reaches DEBOUNCE; counter returns to 0 at that edge.
  - A glitch shorter than DEBOUNCE synced cycles never changes level_out.
- Latency: a clean input change held long enough appears on level_out and pulse_out SYNC_STAGES+DEBOUNCE edges after the first edge that samples it.
- Qualification: pulse_out[i] is set on the same edge level_out[i] toggles, only if en=1 and mode[i] matches the direction (0->1 rise, 1->0 fall). It is high exactly one cycle.
- mode=00 or en=0: no pulse, no sticky set, no count; sync and debounce keep tracking so level_out stays correct. Re-enabling produces no spurious edge.
- Input high at reset release: reported as a rising edge once debounced.
- sticky[i] sets on a qualified pulse and stays set until clr[i].
- count[i] increments on each qualified pulse and saturates at 2^CNT_W-1 (no wrap). clr[i] zeroes it.
- Clear and qualified event on the same edge: event wins; sticky stays/becomes 1 and count becomes 1. The event is never lost.
- irq is combinational from registered sticky and the irq_mask input. Masking takes effect in the same cycle.
- Channels are fully independent; simultaneous events on multiple channels are all recorded.

Decomposition:
- Shared package edge_det_pkg: mode encodings EDGE_NONE=2'b00, EDGE_RISE=2'b01, EDGE_FALL=2'b10, EDGE_BOTH=2'b11.
- Sub-module edge_det_ch: one channel covering sync chain, debounce counter, level register, qualification, sticky, counter. Instantiated CH times via generate.
- Top edge_det_multi: port slicing and irq reduction only.

Test Plan:
1. CH=4, SYNC_STAGES=2, DEBOUNCE=3. ch0 mode=01, en=1, sig_in[0] 0->1 held -> level_out[0]=1 and pulse_out[0]=1 for exactly one cycle 5 edges later; sticky[0]=1, count[0]=1; irq=1 when irq_mask[0]=1, 0 when masked.
2. ch1 mode=11, 2-cycle high glitch on sig_in[1] -> level_out[1], pulse_out[1], sticky[1], count[1] remain 0. A 3-cycle pulse -> rise then fall pulses, count[1]=2.
3. ch2 mode=10, rise then fall with 10-cycle spacing -> level_out tracks both changes; only the fall pulses; count[2]=1.
4. ch3 mode=11, 20 clean toggles -> count[3] saturates at 15 and holds; clr[3] -> count[3]=0, sticky[3]=0 next cycle.
5. clr[0] asserted on the same edge as a qualified ch0 pulse -> sticky[0]=1, count[0]=1 afterwards.
6. en=0 during a ch0 rise -> level_out[0]=1, no pulse/sticky/count. en->1 afterwards -> no pulse. rst asserted mid-debounce -> all outputs 0 next cycle and no later pulse from the aborted change.
